// File: rtl/mest_pro_display_scan.sv
// Time-multiplexed hex display scanner feeding a registered 7-segment decoder.
// Optional leading-zero suppression is enabled by defining MEST_PRO_LZ_BLANK_EN.
module mest_pro_display_scan #(
  parameter int unsigned MEM_WIDTH    = 16,
  parameter int unsigned REFRESH_DIV  = 1000,
  parameter int unsigned BLANK_CYCLES = 16,
  localparam int unsigned NUM_DIGITS  = (MEM_WIDTH + 3) / 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_enable,
  input  logic                  i_load_valid,
  output logic                  o_load_ready,
  input  logic [MEM_WIDTH-1:0]  i_load_val,
  output logic [MEM_WIDTH-1:0]  o_digit_val,
  output logic                  o_digit_oe,
  output logic [NUM_DIGITS-1:0] o_digit_sel,
  output logic                  o_frame_done
);

  localparam int unsigned PadW   = 4 * NUM_DIGITS;
  localparam int unsigned CntMax = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CntW   = $clog2((CntMax < 2) ? 2 : CntMax);
  localparam int unsigned IdxW   = $clog2((NUM_DIGITS < 2) ? 2 : NUM_DIGITS);

  localparam logic [CntW-1:0] ShowLast  = CntW'(REFRESH_DIV - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [IdxW-1:0] IdxLast   = IdxW'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {StIdle, StBlank, StShow} state_e;

  localparam state_e StSlotStart = (BLANK_CYCLES == 0) ? StShow : StBlank;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [MEM_WIDTH-1:0]  disp_q, disp_d, pend_q;
  logic                  ready_q, ready_d;
  logic                  oe_q, oe_d;
  logic [MEM_WIDTH-1:0]  val_q, val_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;
  logic                  fd_q, fd_d;
  logic                  capture, commit, shown;
  logic [PadW-1:0]       disp_pad;
  logic [3:0]            nib;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (!i_enable) begin
      state_d = StIdle;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StSlotStart;
          idx_d   = '0;
          cnt_d   = '0;
        end
        StBlank: begin
          if (cnt_q == BlankLast) begin
            state_d = StShow;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow: begin
          if (cnt_q == ShowLast) begin
            state_d = StSlotStart;
            cnt_d   = '0;
            idx_d   = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Pending commits only while idle or on the frame-done cycle, so a frame never mixes values.
  always_comb begin
    capture = i_load_valid & ready_q;
    commit  = ~ready_q & ((state_q == StIdle) | fd_q);
    disp_d  = commit ? pend_q : disp_q;
    ready_d = ready_q;
    if (capture) begin
      ready_d = 1'b0;
    end else if (commit) begin
      ready_d = 1'b1;
    end
  end

  always_comb begin
    disp_pad = PadW'(disp_d);
    nib      = disp_pad[{idx_d, 2'b00} +: 4];
`ifdef MEST_PRO_LZ_BLANK_EN
    shown = (idx_d == '0);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((IdxW'(i) >= idx_d) && (disp_pad[4*i +: 4] != 4'h0)) shown = 1'b1;
    end
`else
    shown = 1'b1;
`endif
    oe_d  = (state_d == StShow) & shown;
    val_d = '0;
    if (state_d == StShow) val_d = MEM_WIDTH'(nib);
    // Select lags oe by one cycle to line up with the decoder's output register.
    sel_d = oe_q ? (NUM_DIGITS'(1) << idx_q) : '0;
    fd_d  = (state_d == StShow) & (cnt_d == ShowLast) & (idx_d == IdxLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
      oe_q    <= 1'b0;
      val_q   <= '0;
      sel_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      if (capture) pend_q <= i_load_val;
      ready_q <= ready_d;
      oe_q    <= oe_d;
      val_q   <= val_d;
      sel_q   <= sel_d;
      fd_q    <= fd_d;
    end
  end

  assign o_load_ready = ready_q;
  assign o_digit_val  = val_q;
  assign o_digit_oe   = oe_q;
  assign o_digit_sel  = sel_q;
  assign o_frame_done = fd_q;

endmodule
